// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue
//   Instruction-fetch front end. Issues sequential fetch requests over a
//   valid/ready memory interface, tracks in-order responses of variable
//   latency, and buffers fetched instructions in a DEPTH-entry prefetch
//   queue that feeds decode. Supports branch redirect (flushes queued and
//   in-flight instructions) and halt (freezes request issue).
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   halt              block new requests (fetch_pc holds)
//   redirect_valid    taken branch/jump this cycle, target on redirect_pc
//   imem_req_*        fetch request (valid/ready, address)
//   imem_rsp_*        in-order fetch response (always accepted)
//   instr_valid/ready queue head handshake towards decode
//   instr, instr_pc   head instruction and its PC (hold when empty)
//   occupancy         number of queued instructions
module ifetch_prefetch_queue #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       halt,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [PC_W-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INSTR_W-1:0]         imem_rsp_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [INSTR_W-1:0]         instr,
    output logic [PC_W-1:0]            instr_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    // Control state
    logic                 in_reset;
    logic [PC_W-1:0]      fetch_pc;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     drop_cnt;
    logic [AW-1:0]        q_rd, q_wr;
    logic [AW-1:0]        f_rd, f_wr;
    logic [INSTR_W-1:0]   hold_instr;
    logic [PC_W-1:0]      hold_pc;

    // Storage (no reset needed: validity is tracked by pointers/counters)
    logic [INSTR_W-1:0]   q_instr [DEPTH];
    logic [PC_W-1:0]      q_pc    [DEPTH];
    logic [PC_W-1:0]      f_pc    [DEPTH];

    logic credit;
    logic req_fire;
    logic rsp_drop;
    logic q_push;
    logic q_pop;

    // Queued plus in-flight entries never exceed DEPTH, so every response
    // has a free queue slot waiting for it.
    assign credit = ({1'b0, occupancy} + {1'b0, outstanding}) < (CNT_W+1)'(DEPTH);

    assign imem_req_valid = !in_reset && !halt && !redirect_valid && credit;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign q_push   = imem_rsp_valid && !rsp_drop && !redirect_valid;

    assign instr_valid = (occupancy != '0);
    assign q_pop       = instr_valid && instr_ready && !redirect_valid;

    // When empty, re-present whatever was shown the previous cycle.
    assign instr    = instr_valid ? q_instr[q_rd] : hold_instr;
    assign instr_pc = instr_valid ? q_pc[q_rd]    : hold_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_reset    <= 1'b1;
            fetch_pc    <= PC_W'(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
            occupancy   <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            f_rd        <= '0;
            f_wr        <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
        end else begin
            in_reset   <= 1'b0;
            hold_instr <= instr;
            hold_pc    <= instr_pc;

            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (req_fire)       f_wr <= f_wr + AW'(1);
            if (imem_rsp_valid) f_rd <= f_rd + AW'(1);

            if (redirect_valid) begin
                // No request issues this cycle, so whatever is still
                // outstanding after this cycle's response must be dropped.
                fetch_pc  <= redirect_pc;
                drop_cnt  <= outstanding - CNT_W'(imem_rsp_valid);
                occupancy <= '0;
                q_wr      <= q_rd;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_W'(PC_STEP);
                if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
                case ({q_push, q_pop})
                    2'b10:   occupancy <= occupancy + CNT_W'(1);
                    2'b01:   occupancy <= occupancy - CNT_W'(1);
                    default: occupancy <= occupancy;
                endcase
                if (q_push) q_wr <= q_wr + AW'(1);
                if (q_pop)  q_rd <= q_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) f_pc[f_wr] <= fetch_pc;
        if (q_push) begin
            q_instr[q_wr] <= imem_rsp_data;
            q_pc[q_wr]    <= f_pc[f_rd];
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed testbench for ifetch_prefetch_queue with a fixed-latency
// in-order instruction memory model.
module tb_ifetch_prefetch_queue;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               halt;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [2:0]         occupancy;

    always #5 clk = ~clk;

    ifetch_prefetch_queue #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(0), .PC_STEP(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .halt(halt),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .occupancy(occupancy)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int lat       = 1;
    int acc_count = 0;

    typedef struct {
        int              due;
        logic [PC_W-1:0] addr;
    } mreq_t;
    mreq_t mq[$];

    function automatic logic [31:0] mem_data(input logic [7:0] a);
        return {16'hC0DE, ~a, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request handshake with inputs settled, advance
    // the memory model, present the response due in the new cycle, and
    // return at the following negative edge.
    task automatic step();
        logic            acc;
        logic [PC_W-1:0] a;
        logic            rst_s;
        #1;
        acc   = imem_req_valid && imem_req_ready;
        a     = imem_req_addr;
        rst_s = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            mq.delete();
        end else if (acc) begin
            mq.push_back(mreq_t'{due: cyc + lat - 1, addr: a});
            acc_count++;
        end
        if (!rst_s && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        acc_count = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        @(negedge clk);

        // Reset state
        step();
        step();
        chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid),    32'd0);
        chk("rst_occupancy",   32'(occupancy),      32'd0);
        chk("rst_instr",       instr,               32'd0);
        chk("rst_instr_pc",    32'(instr_pc),       32'd0);

        // Sequential fetch, 1-cycle memory
        reset = 1'b0; instr_ready = 1'b1;
        step();
        chk("seq_req_valid", 32'(imem_req_valid), 32'd1);
        chk("seq_req_addr0", 32'(imem_req_addr),  32'h00);
        step();
        chk("seq_valid_n1",  32'(instr_valid),    32'd0);
        chk("seq_req_addr1", 32'(imem_req_addr),  32'h04);
        step();
        chk("seq_valid_n2",  32'(instr_valid),    32'd1);
        chk("seq_pc0",       32'(instr_pc),       32'h00);
        chk("seq_instr0",    instr,               mem_data(8'h00));
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_pc",    32'(instr_pc),    32'(4 * i));
        end
        chk("seq_occupancy", 32'(occupancy), 32'd1);

        // Backpressure
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("bp_occupancy",  32'(occupancy),      32'd4);
        chk("bp_req_valid",  32'(imem_req_valid), 32'd0);
        chk("bp_head_pc",    32'(instr_pc),       32'h00);
        step();
        chk("bp_accepts",    32'(acc_count),      32'd4);
        chk("bp_occ_hold",   32'(occupancy),      32'd4);
        instr_ready = 1'b1;
        step();
        chk("bp_pop_pc",     32'(instr_pc),       32'h04);
        chk("bp_pop_occ",    32'(occupancy),      32'd3);
        chk("bp_resume",     32'(imem_req_valid), 32'd1);
        chk("bp_resume_addr",32'(imem_req_addr),  32'h10);

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        step();
        chk("rd_occupancy",  32'(occupancy),      32'd0);
        chk("rd_no_req",     32'(imem_req_valid), 32'd0);
        chk("rd_fetch_pc",   32'(imem_req_addr),  32'h40);
        redirect_valid = 1'b0;
        step();
        step();
        chk("rd_dropped_occ",   32'(occupancy),   32'd0);
        chk("rd_dropped_valid", 32'(instr_valid), 32'd0);
        step();
        step();
        chk("rd_first_valid", 32'(instr_valid), 32'd1);
        chk("rd_first_pc",    32'(instr_pc),    32'h40);
        chk("rd_first_instr", instr,            mem_data(8'h40));
        step();
        chk("rd_second_pc",   32'(instr_pc),    32'h44);

        // Halt for 5 cycles mid-stream
        lat = 1;
        do_reset();
        step();
        step();
        halt = 1'b1; acc_count = 0;
        step();
        chk("halt_no_req",   32'(imem_req_valid), 32'd0);
        chk("halt_inflight", 32'(instr_pc),       32'h04);
        chk("halt_pc_held",  32'(imem_req_addr),  32'h08);
        for (int i = 0; i < 4; i++) step();
        chk("halt_accepts",  32'(acc_count),      32'd0);
        chk("halt_addr",     32'(imem_req_addr),  32'h08);
        chk("halt_empty",    32'(instr_valid),    32'd0);
        chk("halt_hold_pc",  32'(instr_pc),       32'h04);
        halt = 1'b0;
        #1;
        chk("halt_resume",      32'(imem_req_valid), 32'd1);
        chk("halt_resume_addr", 32'(imem_req_addr),  32'h08);
        step();
        step();
        chk("halt_next_valid", 32'(instr_valid), 32'd1);
        chk("halt_next_pc",    32'(instr_pc),    32'h08);

        // Wrap: redirect to 0xF8 while a response arrives
        redirect_valid = 1'b1; redirect_pc = 8'hF8;
        step();
        chk("wrap_flush_occ", 32'(occupancy),      32'd0);
        chk("wrap_no_req",    32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("wrap_rsp_dropped", 32'(instr_valid), 32'd0);
        step();
        chk("wrap_pc_f8",    32'(instr_pc), 32'hF8);
        chk("wrap_instr_f8", instr,         mem_data(8'hF8));
        step();
        chk("wrap_pc_fc",    32'(instr_pc), 32'hFC);
        step();
        chk("wrap_pc_00",    32'(instr_pc), 32'h00);
        step();
        chk("wrap_pc_04",    32'(instr_pc), 32'h04);

        // Reset with a full queue and halt asserted
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("fr_full_occ", 32'(occupancy), 32'd4);
        halt = 1'b1; reset = 1'b1;
        step();
        chk("fr_instr_valid", 32'(instr_valid),    32'd0);
        chk("fr_occupancy",   32'(occupancy),      32'd0);
        chk("fr_req_valid",   32'(imem_req_valid), 32'd0);
        chk("fr_instr",       instr,               32'd0);
        chk("fr_instr_pc",    32'(instr_pc),       32'd0);
        reset = 1'b0; halt = 1'b0;
        step();
        chk("fr_first_req",  32'(imem_req_valid), 32'd1);
        chk("fr_first_addr", 32'(imem_req_addr),  32'h00);
        step();
        step();
        chk("fr_first_pc",   32'(instr_pc),       32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
